// File: rtl/adma_ram_arbiter_if.sv
// Bundle of the three ADMA-side master ports and the shared system-RAM port.
// The arbiter sits on the slave modport; masters and the RAM sit on the master side.
interface adma_ram_arbiter_if;
  logic        req0, req1, req2;
  logic        lock0, lock1, lock2;
  logic        we0, we1, we2;
  logic [63:0] addr0, addr1, addr2;
  logic [31:0] wdata0, wdata1, wdata2;
  logic        gnt0, gnt1, gnt2;
  logic        rvalid0, rvalid1, rvalid2;
  logic [31:0] rdata;
  logic [63:0] ram_address;
  logic        ram_read, ram_write;
  logic [31:0] data_to_ram;
  logic [31:0] data_from_ram;

  modport slave (
    input  req0, req1, req2, lock0, lock1, lock2, we0, we1, we2,
           addr0, addr1, addr2, wdata0, wdata1, wdata2, data_from_ram,
    output gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2, rdata,
           ram_address, ram_read, ram_write, data_to_ram
  );

  modport master (
    output req0, req1, req2, lock0, lock1, lock2, we0, we1, we2,
           addr0, addr1, addr2, wdata0, wdata1, wdata2, data_from_ram,
    input  gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2, rdata,
           ram_address, ram_read, ram_write, data_to_ram
  );
endinterface

// File: rtl/adma_ram_arbiter.sv
// Round-robin owner of the single system-RAM port for descriptor fetch, data
// transfer and host access; read data is steered back by a tag pipe of RD_LAT stages.
module adma_ram_arbiter #(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input logic               CLK,
  input logic               RESET,
  adma_ram_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [1:0]  owner;
  logic [1:0]  last;
  logic [7:0]  count;
  logic [2:0]  gnt;
  logic [2:0]  req;
  logic [2:0]  win;
  logic        own_req, own_lock, own_we;
  logic [63:0] own_addr;
  logic [31:0] own_wdata;
  logic        accept;
  logic        others_req;
  logic        release_now;

  logic [RD_LAT-1:0] tag_vld_p;
  logic [1:0]        tag_id_p [RD_LAT];

  // Priority scan last+1, last+2, last; returns {found, index}.
  function automatic logic [2:0] pick(input logic [1:0] lst, input logic [2:0] r);
    logic [1:0] c;
    pick = 3'b000;
    for (int k = 3; k >= 1; k--) begin
      c = 2'((int'(lst) + k) % 3);
      if (r[c]) pick = {1'b1, c};
    end
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic burst_done(input logic [7:0] c);
    return ({1'b0, c} + 9'd1) >= 9'(MAX_BURST);
  endfunction

  assign req = {bus.req2, bus.req1, bus.req0};
  assign win = pick(last, req);

  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (owner)
      2'd0: begin own_req = bus.req0; own_lock = bus.lock0; own_we = bus.we0; own_addr = bus.addr0; own_wdata = bus.wdata0; end
      2'd1: begin own_req = bus.req1; own_lock = bus.lock1; own_we = bus.we1; own_addr = bus.addr1; own_wdata = bus.wdata1; end
      2'd2: begin own_req = bus.req2; own_lock = bus.lock2; own_we = bus.we2; own_addr = bus.addr2; own_wdata = bus.wdata2; end
      default: ;
    endcase
  end

  // Encoding 3 leaves own_req low, so it never accepts and falls back to IDLE.
  assign accept      = (state == BUSY) && own_req;
  assign others_req  = |(req & ~(3'b001 << owner));
  assign release_now = !own_req || (burst_done(count) && !own_lock && others_req);

  assign bus.ram_read    = accept & ~own_we;
  assign bus.ram_write   = accept & own_we;
  assign bus.ram_address = accept ? own_addr : '0;
  assign bus.data_to_ram = accept ? own_wdata : '0;
  assign bus.rdata       = bus.data_from_ram;
  assign {bus.gnt2, bus.gnt1, bus.gnt0} = gnt;

  assign bus.rvalid0 = tag_vld_p[RD_LAT-1] && (tag_id_p[RD_LAT-1] == 2'd0);
  assign bus.rvalid1 = tag_vld_p[RD_LAT-1] && (tag_id_p[RD_LAT-1] == 2'd1);
  assign bus.rvalid2 = tag_vld_p[RD_LAT-1] && (tag_id_p[RD_LAT-1] == 2'd2);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      owner <= 2'd0;
      last  <= 2'd2;
      count <= 8'd0;
      gnt   <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (win[2]) begin
            owner <= win[1:0];
            last  <= win[1:0];
            count <= 8'd0;
            gnt   <= 3'b001 << win[1:0];
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept) count <= sat_inc(count);
          if (release_now) begin
            gnt   <= 3'b000;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= 3'b000;
          state <= IDLE;
        end
      endcase
    end
  end

  // Read-tag pipe, stage 0 is the accept cycle; only the valid bits are reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= accept & ~own_we;
      for (int k = 1; k < RD_LAT; k++) tag_vld_p[k] <= tag_vld_p[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    tag_id_p[0] <= owner;
    for (int k = 1; k < RD_LAT; k++) tag_id_p[k] <= tag_id_p[k-1];
  end
endmodule

// File: tb/tb_adma_ram_arbiter.sv
// Directed bench for adma_ram_arbiter: grants and strobes checked inline,
// read returns checked against a scoreboard of issued reads (port, data, due cycle).
module tb_adma_ram_arbiter;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  adma_ram_arbiter_if bus();

  adma_ram_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rd_t;
  rd_t sb[$];

  logic [31:0] rd_pipe [RD_LAT];

  function automatic logic [31:0] ram_val(input logic [63:0] a);
    return (a == 64'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // RAM model: data for a read strobed in cycle N is on data_from_ram in N+RD_LAT.
  always @(posedge CLK) begin
    rd_pipe[0] <= bus.ram_read ? ram_val(bus.ram_address) : 32'h0;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.data_from_ram = rd_pipe[RD_LAT-1];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] gnts();
    return {bus.gnt2, bus.gnt1, bus.gnt0};
  endfunction

  function automatic logic [2:0] rvs();
    return {bus.rvalid2, bus.rvalid1, bus.rvalid0};
  endfunction

  task automatic nxt();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic l, input logic w,
                          input logic [63:0] a, input logic [31:0] d);
    case (p)
      0: begin bus.req0 = r; bus.lock0 = l; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
      1: begin bus.req1 = r; bus.lock1 = l; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
      default: begin bus.req2 = r; bus.lock2 = l; bus.we2 = w; bus.addr2 = a; bus.wdata2 = d; end
    endcase
  endtask

  task automatic clear_all();
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
  endtask

  task automatic push_rd(input int p, input logic [63:0] a);
    rd_t e;
    e.port = p;
    e.data = ram_val(a);
    e.due  = cyc + RD_LAT;
    sb.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"}, 64'(gnts()), 64'h0);
    chk({tag, "_rvalid"}, 64'(rvs()), 64'h0);
    chk({tag, "_ram_read"}, 64'(bus.ram_read), 64'h0);
    chk({tag, "_ram_write"}, 64'(bus.ram_write), 64'h0);
    chk({tag, "_ram_address"}, bus.ram_address, 64'h0);
    chk({tag, "_data_to_ram"}, 64'(bus.data_to_ram), 64'h0);
  endtask

  // Every rvalid must match the oldest outstanding read: port, data and cycle.
  always @(negedge CLK) begin
    logic [2:0] rv;
    rd_t        e;
    rv = rvs();
    if (rv != 3'b000) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL rvalid_unexpected observed=%b expected=none", rv);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rvalid_port", 64'(rv), 64'(3'b001 << e.port));
        chk("rdata", 64'(bus.rdata), 64'(e.data));
        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    RESET = 1'b1;
    clear_all();
    nxt(); settle();
    nxt(); settle();
    chk_idle_outputs("reset");

    // Round-robin: all three requesting, each drops and re-raises after one read.
    nxt(); RESET = 1'b0;
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 1'b0, 64'h10 * (p + 1), 32'h0);
    settle();
    chk("rr_idle_gnt", 64'(gnts()), 64'h0);
    for (int k = 0; k < 4; k++) begin
      int p;
      p = k % 3;
      nxt(); settle();
      chk("rr_gnt", 64'(gnts()), 64'(3'b001 << p));
      chk("rr_ram_read", 64'(bus.ram_read), 64'h1);
      chk("rr_addr", bus.ram_address, 64'h10 * (p + 1));
      push_rd(p, 64'h10 * (p + 1));
      nxt(); set_port(p, 1'b0, 1'b0, 1'b0, 64'h10 * (p + 1), 32'h0); settle();
      chk("rr_drop_gnt", 64'(gnts()), 64'(3'b001 << p));
      chk("rr_drop_read", 64'(bus.ram_read), 64'h0);
      chk("rr_drop_addr", bus.ram_address, 64'h0);
      nxt(); set_port(p, 1'b1, 1'b0, 1'b0, 64'h10 * (p + 1), 32'h0); settle();
      chk("rr_turnaround_gnt", 64'(gnts()), 64'h0);
    end
    nxt(); clear_all(); settle();
    chk("rr_last_gnt", 64'(gnts()), 64'b010);
    chk("rr_last_read", 64'(bus.ram_read), 64'h0);
    nxt(); settle();
    chk("rr_end_gnt", 64'(gnts()), 64'h0);

    // Single read by port 1.
    nxt(); set_port(1, 1'b1, 1'b0, 1'b0, 64'h100, 32'h0); settle();
    chk("single_req_gnt", 64'(gnts()), 64'h0);
    nxt(); settle();
    chk("single_gnt", 64'(gnts()), 64'b010);
    chk("single_read", 64'(bus.ram_read), 64'h1);
    chk("single_write", 64'(bus.ram_write), 64'h0);
    chk("single_addr", bus.ram_address, 64'h100);
    push_rd(1, 64'h100);
    nxt(); set_port(1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0); settle();
    chk("single_drop_read", 64'(bus.ram_read), 64'h0);
    nxt(); settle();
    chk("single_rvalid1", 64'(bus.rvalid1), 64'h1);
    chk("single_rdata", 64'(bus.rdata), 64'hDEADBEEF);

    // Locked burst by port 0 beyond MAX_BURST while port 1 waits to write.
    nxt();
    set_port(0, 1'b1, 1'b1, 1'b0, 64'h40, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b1, 64'h80, 32'h1000);
    settle();
    chk("lock_idle_gnt", 64'(gnts()), 64'h0);
    for (int i = 0; i < 5; i++) begin
      nxt(); set_port(0, 1'b1, 1'b1, 1'b0, 64'h40 + 64'(4 * i), 32'h0); settle();
      chk("lock_gnt", 64'(gnts()), 64'b001);
      chk("lock_read", 64'(bus.ram_read), 64'h1);
      chk("lock_addr", bus.ram_address, 64'h40 + 64'(4 * i));
      push_rd(0, 64'h40 + 64'(4 * i));
    end
    nxt(); set_port(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0); settle();
    chk("lock_drop_gnt", 64'(gnts()), 64'b001);
    chk("lock_drop_read", 64'(bus.ram_read), 64'h0);
    nxt(); settle();
    chk("lock_turnaround_gnt", 64'(gnts()), 64'h0);

    // Forced release: port 1 writes, port 2 competing, exactly MAX_BURST writes.
    nxt(); set_port(2, 1'b1, 1'b0, 1'b1, 64'h300, 32'h2222); settle();
    for (int i = 0; i < MAX_BURST; i++) begin
      if (i > 0) begin
        nxt(); set_port(1, 1'b1, 1'b0, 1'b1, 64'h80, 32'h1000 + 32'(i)); settle();
      end
      chk("burst_gnt", 64'(gnts()), 64'b010);
      chk("burst_write", 64'(bus.ram_write), 64'h1);
      chk("burst_addr", bus.ram_address, 64'h80);
      chk("burst_wdata", 64'(bus.data_to_ram), 64'h1000 + 64'(i));
    end
    nxt(); settle();
    chk("burst_release_gnt", 64'(gnts()), 64'h0);
    chk("burst_release_write", 64'(bus.ram_write), 64'h0);
    nxt(); settle();
    chk("burst_next_gnt", 64'(gnts()), 64'b100);
    chk("burst_next_addr", bus.ram_address, 64'h300);
    chk("burst_next_wdata", 64'(bus.data_to_ram), 64'h2222);
    nxt(); set_port(2, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0); settle();
    chk("burst_p2_drop_write", 64'(bus.ram_write), 64'h0);
    nxt(); settle();
    chk("burst_p2_turnaround", 64'(gnts()), 64'h0);

    // No competitor: port 1 keeps ownership past MAX_BURST.
    for (int i = 0; i < MAX_BURST + 2; i++) begin
      nxt(); set_port(1, 1'b1, 1'b0, 1'b1, 64'h84, 32'h2000 + 32'(i)); settle();
      chk("solo_gnt", 64'(gnts()), 64'b010);
      chk("solo_wdata", 64'(bus.data_to_ram), 64'h2000 + 64'(i));
    end
    nxt(); set_port(1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0); settle();
    chk("solo_drop_write", 64'(bus.ram_write), 64'h0);
    nxt(); settle();
    chk("solo_end_gnt", 64'(gnts()), 64'h0);

    // Steering: port 0's last read returns while port 2 already owns the RAM.
    nxt(); set_port(0, 1'b1, 1'b0, 1'b0, 64'h600, 32'h0); settle();
    chk("steer_idle_gnt", 64'(gnts()), 64'h0);
    for (int i = 0; i < MAX_BURST; i++) begin
      nxt();
      set_port(0, 1'b1, 1'b0, 1'b0, 64'h600 + 64'(4 * i), 32'h0);
      if (i == 0) set_port(2, 1'b1, 1'b0, 1'b0, 64'h700, 32'h0);
      settle();
      chk("steer_gnt0", 64'(gnts()), 64'b001);
      chk("steer_addr", bus.ram_address, 64'h600 + 64'(4 * i));
      push_rd(0, 64'h600 + 64'(4 * i));
    end
    nxt(); settle();
    chk("steer_turnaround", 64'(gnts()), 64'h0);
    nxt(); settle();
    chk("steer_gnt2", 64'(gnts()), 64'b100);
    chk("steer_rvalid", 64'(rvs()), 64'b001);
    chk("steer_rdata", 64'(bus.rdata), 64'(ram_val(64'h60C)));
    push_rd(2, 64'h700);
    nxt(); clear_all(); settle();
    chk("steer_drop_read", 64'(bus.ram_read), 64'h0);
    nxt(); settle();
    chk("steer_end_gnt", 64'(gnts()), 64'h0);

    // Reset in the middle of a read burst discards in-flight tags.
    nxt(); set_port(0, 1'b1, 1'b0, 1'b0, 64'h500, 32'h0); settle();
    nxt(); settle();
    chk("rst_burst_gnt", 64'(gnts()), 64'b001);
    push_rd(0, 64'h500);
    nxt(); set_port(0, 1'b1, 1'b0, 1'b0, 64'h504, 32'h0); settle();
    chk("rst_burst_read", 64'(bus.ram_read), 64'h1);
    nxt(); RESET = 1'b1; set_port(0, 1'b1, 1'b0, 1'b0, 64'h508, 32'h0); settle();
    chk("rst_prior_rvalid0", 64'(bus.rvalid0), 64'h1);
    nxt();
    set_port(1, 1'b1, 1'b0, 1'b0, 64'h900, 32'h0);
    set_port(2, 1'b1, 1'b0, 1'b0, 64'hA00, 32'h0);
    settle();
    chk_idle_outputs("rst_mid");
    nxt(); RESET = 1'b0; settle();
    chk("rst_release_gnt", 64'(gnts()), 64'h0);
    chk("rst_release_rvalid", 64'(rvs()), 64'h0);
    nxt(); settle();
    chk("rst_first_gnt", 64'(gnts()), 64'b001);
    chk("rst_first_addr", bus.ram_address, 64'h508);
    push_rd(0, 64'h508);
    nxt(); clear_all(); settle();
    repeat (RD_LAT + 3) nxt();
    settle();
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adma_ram_arbiter.md
# adma_ram_arbiter

Shares the single system-RAM port among the three ADMA-side masters: descriptor fetch (port 0), data transfer (port 1) and host register/CPU access (port 2). Grants ownership with rotating round-robin priority, supports locked bursts so a 96-bit descriptor fetch is never split, and bounds unlocked bursts so no master starves. Read data is steered back to the issuing master even after ownership changes. Sits between the ADMA state machine's fetch/transfer units, the host bus interface, and the RAM.

## Interface
Parameters:
- RD_LAT, 1: RAM read latency in cycles, from `ram_read` to valid `data_from_ram`. Legal range 1..4.
- MAX_BURST, 8: maximum accepted unlocked accesses per grant when another master is pending. Legal range 1..255.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high.
- req0..req2  in  1 each  access request from master i; held until served.
- lock0..lock2  in  1 each  keep ownership regardless of MAX_BURST while high.
- we0..we2  in  1 each  1 = write, 0 = read.
- addr0..addr2  in  64 each  RAM address.
- wdata0..wdata2  in  32 each  write data.
- gnt0..gnt2  out  1 each  registered; master i owns the RAM port.
- rvalid0..rvalid2  out  1 each  `rdata` holds read data for master i this cycle.
- rdata  out  32  read data, shared; equals `data_from_ram`.
- ram_address  out  64  to RAM.
- ram_read, ram_write  out  1  RAM strobes; never both high.
- data_to_ram  out  32  to RAM.
- data_from_ram  in  32  from RAM.

## Operation
- States: IDLE and BUSY. Registers: `owner` (2 bits), `last` (2 bits), `count` (8 bits), read-tag pipe of RD_LAT stages, each holding {valid, id}.
- IDLE: if any req is high, select the first requesting index scanning `last`+1, `last`+2, `last` (mod 3). On the next edge: `owner`=winner, `last`=winner, `count`=0, state BUSY. No req: remain in IDLE.
- BUSY: gnt[owner]=1, all other gnt=0. An access is accepted in any cycle with req[owner]=1. `ram_address`=addr[owner], `data_to_ram`=wdata[owner], `ram_write`=req[owner]&we[owner], `ram_read`=req[owner]&~we[owner]. Outside accepted cycles, strobes are 0 and address/data are 0.
- `count` increments on each accepted access and saturates at 255.
- BUSY→IDLE on the next edge when either condition holds:
  - req[owner]=0; or
  - an access is accepted, `count`+1 ≥ MAX_BURST, lock[owner]=0, and any other req is high.
- lock[owner]=1 suppresses the forced release only. Releasing req still releases.
- Forced release with no competitor: remain BUSY; `count` keeps saturating.
- Read tag: every accepted read pushes {1, owner} into stage 0. Writes and idle cycles push {0, x}. rvalid[i]=1 when the last stage is {1, i}. Steering is independent of the current gnt.
- Masters must drop or re-evaluate req on gnt loss. An outstanding request simply re-arbitrates.
- Unused encoding 3 in `owner`: force IDLE next cycle.

## Timing
- Reset values: state IDLE, `owner`=0, `last`=2 (port 0 wins first), `count`=0, tag pipe all invalid. All gnt, all rvalid, `ram_read`, `ram_write` are 0; `ram_address`=0, `data_to_ram`=0.
- Reset mid-burst drops gnt and discards in-flight read tags on the next edge; no rvalid is asserted afterwards.
- Grant latency: req rises at cycle t in IDLE → gnt high at t+1 → first access at t+1.
- Read data: accepted at cycle a → rvalid/rdata at a+RD_LAT.
- Back-to-back accesses: one per cycle while owned.
- Handoff: release condition at cycle t → IDLE at t+1 (gnt all 0) → next gnt at t+2. This is a fixed one-cycle turnaround.
- Simultaneous new requests during BUSY wait for the release. They are arbitrated in the IDLE cycle using the updated `last`.

## Test plan
- Reset: assert RESET mid-read burst with RD_LAT=2 → next cycle all gnt/rvalid/strobes 0, `ram_address`=0. Pending reads produce no rvalid. First grant after reset goes to port 0 when all three request.
- Single read: req1, addr1=0x100, we1=0 at t → gnt1 at t+1, `ram_read`=1, `ram_address`=0x100 at t+1. With RAM returning 0xDEADBEEF, rvalid1=1 and rdata=0xDEADBEEF at t+1+RD_LAT.
- Round-robin: all req held continuously, one access each then req dropped and re-raised → grant order 0,1,2,0 with one idle cycle between grants.
- Locked descriptor fetch: port 0 locked, 3 reads at 0x40/0x44/0x48, MAX_BURST=1, port 1 requesting → three consecutive reads by port 0, gnt1 only after req0 drops.
- Forced release: port 1 unlocked continuous writes, MAX_BURST=4, port 2 requesting → exactly 4 writes, IDLE cycle, gnt2. With port 2 not requesting, port 1 keeps the grant beyond 4 accesses.
- Steering across handoff: RD_LAT=3, port 0 issues a read in its last owned cycle → rvalid0 (not rvalid of the new owner) 3 cycles later while gnt2 is high.
